// File: rtl/axi_stream_frame_buffer_if.sv
// rtl/axi_stream_frame_buffer_if.sv - character stream handshake bundle for the frame buffer
interface axi_stream_frame_buffer_if #(
    parameter int CHAR_LEN = 8
) ();
    logic [CHAR_LEN-1:0] tdata;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axi_stream_frame_buffer.sv
// rtl/axi_stream_frame_buffer.sv - multi-slot stream-to-word frame buffer
// Frames are padded/truncated to N characters and handed out one at a time via run/valid.
module axi_stream_frame_buffer #(
    parameter int                  N        = 32,
    parameter int                  CHAR_LEN = 8,
    parameter int                  NUM_BUF  = 2,
    parameter logic [CHAR_LEN-1:0] PAD_CHAR = '0,
    localparam int                 LW       = $clog2(N + 1),
    localparam int                 FW       = $clog2(NUM_BUF + 1),
    localparam int                 PW       = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    axi_stream_frame_buffer_if.slave     s_axis,
    input  logic                         run,
    output logic                         valid,
    output logic [N*CHAR_LEN-1:0]        q,
    output logic [LW-1:0]                len,
    output logic                         trunc,
    output logic [FW-1:0]                frames
);

    typedef enum logic {ST_IDLE, ST_PRESENT} state_e;

    state_e                state_q, state_d;
    logic [N*CHAR_LEN-1:0] slot_data_q [NUM_BUF];
    logic [LW-1:0]         slot_len_q  [NUM_BUF];
    logic [NUM_BUF-1:0]    slot_trunc_q;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         wi_q, wi_d;
    logic [FW-1:0]         frames_q, frames_d;
    logic                  tready_q, tready_d;
    logic [N*CHAR_LEN-1:0] q_q;
    logic [LW-1:0]         len_q;
    logic                  trunc_q;

    logic                  accept, discard, commit, load, free;
    logic [LW-1:0]         commit_len;
    logic [N*CHAR_LEN-1:0] wr_word;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NUM_BUF - 1)) ? '0 : p + PW'(1);
    endfunction

    assign accept     = s_axis.tvalid && tready_q;
    assign discard    = (wi_q == LW'(N));
    assign commit     = accept && s_axis.tlast;
    assign commit_len = discard ? LW'(N) : wi_q + LW'(1);

    // The first beat pre-fills the whole slot with padding, so no residue survives.
    always_comb begin
        wr_word = (wi_q == '0) ? {N{PAD_CHAR}} : slot_data_q[wr_ptr_q];
        for (int k = 0; k < N; k++) begin
            if (wi_q == LW'(k)) begin
                wr_word[k*CHAR_LEN +: CHAR_LEN] = s_axis.tdata;
            end
        end
    end

    always_comb begin
        wi_d = wi_q;
        if (commit) begin
            wi_d = '0;
        end else if (accept && !discard) begin
            wi_d = wi_q + LW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        free    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run && (frames_q != '0)) begin
                    state_d = ST_PRESENT;
                    load    = 1'b1;
                end
            end
            ST_PRESENT: begin
                if (!run) begin
                    state_d = ST_IDLE;
                    free    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        frames_d = frames_q;
        if (commit && !free) begin
            frames_d = frames_q + FW'(1);
        end else if (!commit && free) begin
            frames_d = frames_q - FW'(1);
        end
        tready_d = (frames_d < FW'(NUM_BUF)) || (wi_d == LW'(N));
    end

    always_ff @(posedge ACLK) begin
        if (accept && !discard) begin
            slot_data_q[wr_ptr_q] <= wr_word;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wi_q         <= '0;
            frames_q     <= '0;
            tready_q     <= 1'b0;
            q_q          <= '0;
            len_q        <= '0;
            trunc_q      <= 1'b0;
            slot_trunc_q <= '0;
            for (int i = 0; i < NUM_BUF; i++) begin
                slot_len_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wi_q     <= wi_d;
            frames_q <= frames_d;
            tready_q <= tready_d;
            if (accept) begin
                if (wi_q == '0) begin
                    slot_trunc_q[wr_ptr_q] <= 1'b0;
                end else if (discard) begin
                    slot_trunc_q[wr_ptr_q] <= 1'b1;
                end
                if (commit) begin
                    slot_len_q[wr_ptr_q] <= commit_len;
                    wr_ptr_q             <= ptr_inc(wr_ptr_q);
                end
            end
            if (load) begin
                q_q     <= slot_data_q[rd_ptr_q];
                len_q   <= slot_len_q[rd_ptr_q];
                trunc_q <= slot_trunc_q[rd_ptr_q];
            end
            if (free) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    assign s_axis.tready = tready_q;
    assign valid         = (state_q == ST_PRESENT);
    assign q             = q_q;
    assign len           = len_q;
    assign trunc         = trunc_q;
    assign frames        = frames_q;

endmodule
